// File: rtl/led_step_timer.sv
// Input conditioning and step-rate generation for the LED pattern stage:
// synchronises and debounces SPEED/MODE and produces a one-cycle STEP enable.
module led_step_timer #(
  parameter int SLOW_DIV        = 6000000,
  parameter int FAST_DIV        = 1500000,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic SPEED_IN,
  input  logic MODE_IN,
  output logic SPEED,
  output logic MODE,
  output logic MODE_CHG,
  output logic STEP
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = $clog2(SLOW_DIV);
  localparam logic [CW-1:0] DB_LIM   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] SLOW_LIM = DW'(SLOW_DIV - 1);
  localparam logic [DW-1:0] FAST_LIM = DW'(FAST_DIV - 1);

  // Bit 0 carries SPEED, bit 1 carries MODE.
  logic [1:0] raw_in;
  logic [1:0] stable;
  logic [1:0] chg_evt;

  assign raw_in = {MODE_IN, SPEED_IN};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CW-1:0]          cnt_reg;
      logic                   stable_reg;
      logic                   sync_bit;

      assign sync_bit    = sync_reg[SYNC_STAGES-1];
      // Change accepted on the same edge the counter would reach its limit.
      assign chg_evt[gi] = (sync_bit != stable_reg) && (cnt_reg == DB_LIM);
      assign stable[gi]  = stable_reg;

      always_ff @(posedge CLOCK) begin
        if (RESET) begin
          sync_reg   <= '0;
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
          if (sync_bit == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LIM) begin
            stable_reg <= sync_bit;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  logic [DW-1:0] div_reg;
  logic [DW-1:0] div_next;
  logic [DW-1:0] limit;
  logic          step_reg;
  logic          step_next;
  logic          mode_chg_reg;

  assign limit = stable[0] ? FAST_LIM : SLOW_LIM;

  // A rate change restarts the period without emitting a step.
  always_comb begin
    div_next  = div_reg + 1'b1;
    step_next = 1'b0;
    if (chg_evt[0]) begin
      div_next = '0;
    end else if (div_reg >= limit) begin
      div_next  = '0;
      step_next = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      div_reg      <= '0;
      step_reg     <= 1'b0;
      mode_chg_reg <= 1'b0;
    end else begin
      div_reg      <= div_next;
      step_reg     <= step_next;
      mode_chg_reg <= chg_evt[1];
    end
  end

  assign SPEED    = stable[0];
  assign MODE     = stable[1];
  assign MODE_CHG = mode_chg_reg;
  assign STEP     = step_reg;

endmodule

// File: tb/tb_led_step_timer.sv
// Randomised scoreboard bench for led_step_timer against a sliding-window
// debounce model and an anchor/period step model.
module tb_led_step_timer;

  localparam int SLOW = 10;
  localparam int FAST = 4;
  localparam int DB   = 4;
  localparam int SYNC = 2;
  localparam int N    = 4096;

  logic CLOCK    = 1'b0;
  logic RESET    = 1'b1;
  logic SPEED_IN = 1'b0;
  logic MODE_IN  = 1'b0;
  logic SPEED, MODE, MODE_CHG, STEP;

  always #5 CLOCK = ~CLOCK;

  led_step_timer #(
    .SLOW_DIV(SLOW), .FAST_DIV(FAST), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SYNC)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .SPEED_IN(SPEED_IN), .MODE_IN(MODE_IN),
    .SPEED(SPEED), .MODE(MODE), .MODE_CHG(MODE_CHG), .STEP(STEP)
  );

  typedef struct packed {
    int   n;
    logic sp;
    logic md;
    logic chg;
    logic st;
  } exp_t;

  exp_t exp_q[$];

  bit rst_h[N];
  bit sp_h[N];
  bit md_h[N];
  int cyc = 0;
  bit m_sp = 1'b0;
  bit m_md = 1'b0;
  int anchor = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Level the debouncer observes at edge n: raw input SYNC edges earlier,
  // forced to 0 if a reset touched the synchroniser in between.
  function automatic bit seen(input int n, input bit which);
    if (n - SYNC < 0) return 1'b0;
    for (int k = n - SYNC; k < n; k++)
      if (rst_h[k]) return 1'b0;
    return which ? md_h[n - SYNC] : sp_h[n - SYNC];
  endfunction

  // Output flips at edge n when the last DB observed samples, all on
  // non-reset edges, differ from the current stable value.
  function automatic bit flips(input int n, input bit which, input bit s);
    for (int j = 0; j < DB; j++) begin
      int k;
      k = n - j;
      if (k < 0) return 1'b0;
      if (rst_h[k]) return 1'b0;
      if (seen(k, which) == s) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input int n);
    exp_t e;
    bit sp_flip, md_flip, old_sp;
    e.n = n;
    if (rst_h[n]) begin
      m_sp = 1'b0;
      m_md = 1'b0;
      anchor = n;
      e.sp = 0; e.md = 0; e.chg = 0; e.st = 0;
    end else begin
      sp_flip = flips(n, 1'b0, m_sp);
      md_flip = flips(n, 1'b1, m_md);
      old_sp  = m_sp;
      if (sp_flip) begin
        m_sp   = ~m_sp;
        anchor = n;
        e.st   = 1'b0;
      end else begin
        e.st = (((n - anchor) % (old_sp ? FAST : SLOW)) == 0);
      end
      if (md_flip) m_md = ~m_md;
      e.sp  = m_sp;
      e.md  = m_md;
      e.chg = md_flip;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit sp, input bit md);
    @(negedge CLOCK);
    RESET    = r;
    SPEED_IN = sp;
    MODE_IN  = md;
    rst_h[cyc] = r;
    sp_h[cyc]  = sp;
    md_h[cyc]  = md;
    @(posedge CLOCK);
    model_edge(cyc);
    cyc++;
  endtask

  task automatic hold(input int k, input bit r, input bit sp, input bit md);
    for (int i = 0; i < k; i++) drive(r, sp, md);
  endtask

  task automatic chk(input string name, input int n, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, n, act, exp);
    end
  endtask

  always @(negedge CLOCK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("SPEED", e.n, SPEED, e.sp);
      chk("MODE", e.n, MODE, e.md);
      chk("MODE_CHG", e.n, MODE_CHG, e.chg);
      chk("STEP", e.n, STEP, e.st);
    end
  end

  initial begin
    bit sp, md;
    // Reset then idle: steps every SLOW cycles.
    hold(3, 1, 0, 0);
    hold(35, 0, 0, 0);
    // Speed up and hold.
    hold(30, 0, 1, 0);
    // Short mode bounce, then a held mode change.
    hold(3, 0, 1, 1);
    hold(10, 0, 1, 0);
    hold(15, 0, 1, 1);
    // Single-cycle reset while switches stay high.
    hold(3, 0, 1, 1);
    hold(1, 1, 1, 1);
    hold(30, 0, 1, 1);
    // Both switches low, then both high together.
    hold(20, 0, 0, 0);
    hold(20, 0, 1, 1);
    // Slow down partway through a fast period.
    hold(2, 0, 1, 1);
    hold(25, 0, 0, 1);

    sp = 1'b0;
    md = 1'b1;
    while (cyc < N - 60) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        hold($urandom_range(1, 3), 1, sp, md);
      end else begin
        if (kind < 5) sp = ~sp;
        else if (kind < 9) md = ~md;
        else begin sp = ~sp; md = ~md; end
        hold($urandom_range(1, 25), 0, sp, md);
      end
    end
    hold(5, 0, sp, md);

    @(negedge CLOCK);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_step_timer.md
Name: led_step_timer

Overview:
Upstream timing/input-conditioning stage for the Lab2 LED pattern top level. It takes the raw SPEED and MODE switch inputs and synchronises and debounces them. It also generates the single-cycle STEP enable that advances the 8-bit LED pattern, at one of two rates selected by the debounced SPEED. The pattern stage consumes STEP, SPEED, MODE and MODE_CHG, and runs entirely on CLOCK with no derived clocks.

Parameters:
SLOW_DIV, 6000000, STEP period in CLOCK cycles when SPEED=0 (0.5 s at 12 MHz); must be ≥2
FAST_DIV, 1500000, STEP period in CLOCK cycles when SPEED=1 (0.125 s at 12 MHz); must be ≥2 and ≤SLOW_DIV
DEBOUNCE_CYCLES, 120000, consecutive synchronised samples needed to accept a switch change (10 ms); must be ≥1
SYNC_STAGES, 2, flip-flops in each input synchroniser; must be ≥2

Ports:
CLOCK  in  1  system clock, 12 MHz nominal, rising edge
RESET  in  1  synchronous, active-high reset
SPEED_IN  in  1  raw asynchronous speed switch
MODE_IN  in  1  raw asynchronous mode switch
SPEED  out  1  debounced speed select
MODE  out  1  debounced mode select
MODE_CHG  out  1  one-cycle pulse when debounced MODE changes
STEP  out  1  one-cycle pattern-advance enable

Behaviour:
- Reset (RESET high at a rising edge): all synchroniser flops, SPEED, MODE, MODE_CHG, STEP, the debounce counters and the divider counter clear to 0 on that edge. Reset has priority over all other activity.
- Synchroniser: each raw input passes through a chain of SYNC_STAGES flops. Only the last flop is used downstream.
- Debouncer (independent instance per input):
  - State is a stable value s (drives SPEED/MODE) and a counter c, width clog2(DEBOUNCE_CYCLES+1).
  - If sync==s: c<=0.
  - If sync!=s and c<DEBOUNCE_CYCLES-1: c<=c+1.
  - If sync!=s and c==DEBOUNCE_CYCLES-1: s<=sync, c<=0, and a one-cycle change pulse is raised.
  - Latency: a clean input edge appears on the output at rising edge number SYNC_STAGES+DEBOUNCE_CYCLES after the first edge that samples the new level.
  - A bounce shorter than DEBOUNCE_CYCLES synchronised samples leaves the output unchanged and clears c.
- MODE_CHG: registered. It is high for exactly the one cycle following the edge on which MODE updates, i.e. it is coincident with the new MODE value.
- Divider: counter d, width clog2(SLOW_DIV). Limit L = (SPEED ? FAST_DIV : SLOW_DIV) - 1, evaluated using the current debounced SPEED.
  - If the SPEED change pulse is active: d<=0 and STEP<=0. This has priority over the terminal count, so no STEP is issued on a rate change and the new period starts cleanly.
  - Else if d>=L: d<=0, STEP<=1.
  - Else: d<=d+1, STEP<=0.
- STEP timing: STEP is registered and high for exactly one cycle. Steady-state period is exactly L+1 cycles. The first STEP after reset release is high during cycle L+1, counting the first non-reset edge as edge 1.
- Mid-operation reset: counters clear immediately and any pending STEP is dropped. SPEED and MODE return to 0 even if the switches are high; they re-acquire through the normal debounce path after reset releases.
- Simultaneous SPEED and MODE changes: handled independently. MODE_CHG and the divider restart may occur on the same cycle.
- All outputs are driven directly from flops.

Test Plan:
All tests use SLOW_DIV=10, FAST_DIV=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
1. RESET high for 3 cycles, then low, inputs 0 -> STEP high for one cycle at cycles 10, 20, 30 after release; SPEED=MODE=MODE_CHG=0 throughout.
2. SPEED_IN 0→1, held -> SPEED rises at edge 6 after sampling; divider restarts with no STEP that cycle; subsequent STEPs every 4 cycles.
3. MODE_IN pulsed high for 3 cycles, then 0 -> MODE stays 0 and MODE_CHG is never asserted. Repeat with MODE_IN held high -> MODE=1 at edge 6, MODE_CHG high for exactly that one cycle.
4. With SPEED=1 and STEP period 4, assert RESET for 1 cycle midway between STEPs -> STEP never asserted during reset; SPEED=0 immediately; SPEED returns to 1 six cycles after release; STEPs then resume at the 4-cycle period.
5. Drive SPEED_IN and MODE_IN 0→1 on the same cycle -> SPEED and MODE both update at edge 6; MODE_CHG=1 that cycle; divider restart; next STEP 4 cycles later.
6. Switch SPEED 1→0 when the divider count is 2 -> restart at 0; next STEP 10 cycles after the SPEED update; no double or missing pulse.
